// File: rtl/spi_exe_pkg.sv
// Shared definitions for the SPI execution-unit link (initiator and slave side).
package spi_exe_pkg;
  localparam int M       = 8;
  localparam int N       = 4;
  localparam int FLAG_W  = N;
  localparam int TX_BITS = 24;
  localparam int RX_BITS = M + N;

  localparam int SF = 0;
  localparam int OF = 1;
  localparam int NF = 2;
  localparam int BF = 3;

  typedef enum logic [2:0] {IDLE, SETUP, TX, TURN, RX, HOLD, DONE} state_e;
endpackage

// File: rtl/spi_exe_master_clk_gen.sv
// Serial clock divider: counts H cycles per half-period, toggles o_sck when allowed.
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic i_sclk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_tog,
  output logic o_sck,
  output logic o_tick,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  // Strobes flag the cycle before o_sck actually changes, so they line up with the register update.
  assign o_tick = i_en && (cnt == CW'(CLK_DIV - 1));
  assign o_rise = o_tick && i_tog && !o_sck;
  assign o_fall = o_tick && i_tog && o_sck;

  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      cnt   <= '0;
      o_sck <= 1'b0;
    end else if (i_clr || !i_en) begin
      cnt   <= '0;
      o_sck <= 1'b0;
    end else begin
      cnt <= o_tick ? '0 : cnt + 1'b1;
      if (o_tick && i_tog) o_sck <= ~o_sck;
    end
  end
endmodule

// File: rtl/spi_exe_master.sv
// SPI initiator: shifts out {argA, argB, opcode}, waits a turnaround, captures {result, flags}.
module spi_exe_master
  import spi_exe_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int TURN_BITS = 2
) (
  input  logic         i_sclk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic [M-1:0] i_argA,
  input  logic [M-1:0] i_argB,
  input  logic [N-1:0] i_oper,
  output logic         o_busy,
  output logic         o_done,
  output logic [M-1:0] o_result,
  output logic [N-1:0] o_flags,
  output logic         o_sck,
  output logic         o_cs_n,
  output logic         o_mosi,
  input  logic         i_miso
);
  localparam int BMAX0 = (TX_BITS > RX_BITS) ? TX_BITS : RX_BITS;
  localparam int BMAX  = (BMAX0 > TURN_BITS) ? BMAX0 : TURN_BITS;
  localparam int BW    = $clog2(BMAX + 1);

  state_e               state, nxt;
  logic                 abort, act, act_nxt, tog;
  logic                 tick, rise, fall;
  logic [BW-1:0]        bcnt;
  logic [TX_BITS-1:0]   tx_word, tx_sh;
  logic [RX_BITS-1:0]   rx_sh;

  assign act     = state inside {SETUP, TX, TURN, RX, HOLD};
  assign act_nxt = nxt inside {SETUP, TX, TURN, RX, HOLD};
  assign tog     = state inside {TX, TURN, RX};
  assign tx_word = {i_argA, i_argB, i_oper, {(TX_BITS - 2*M - N){1'b0}}};

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk (
    .i_sclk (i_sclk),
    .i_rst  (i_rst),
    .i_clr  (abort),
    .i_en   (act),
    .i_tog  (tog),
    .o_sck  (o_sck),
    .o_tick (tick),
    .o_rise (rise),
    .o_fall (fall)
  );

  always_comb begin
    nxt   = state;
    abort = 1'b0;
    unique case (state)
      IDLE:  if (i_start) nxt = SETUP;
      SETUP: if (tick) nxt = TX;
      TX:    if (fall && bcnt == BW'(TX_BITS - 1)) nxt = (TURN_BITS == 0) ? RX : TURN;
      TURN:  if (fall && 32'(bcnt) == TURN_BITS - 1) nxt = RX;
      RX:    if (fall && bcnt == BW'(RX_BITS - 1)) nxt = HOLD;
      HOLD:  if (tick) nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (i_abort && act) begin
      abort = 1'b1;
      nxt   = IDLE;
    end
  end

  always_ff @(posedge i_sclk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= IDLE;
      bcnt     <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      o_mosi   <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_cs_n   <= 1'b1;
      o_result <= '0;
      o_flags  <= '0;
    end else begin
      state  <= nxt;
      o_busy <= act_nxt;
      o_cs_n <= !act_nxt;
      o_done <= (nxt == DONE);

      if (abort || state == IDLE) bcnt <= '0;
      else if (fall)              bcnt <= (nxt != state) ? '0 : bcnt + 1'b1;

      // tx_sh holds the bits still to be sent once the MSB is already on the pin.
      if (state == IDLE && i_start) begin
        tx_sh  <= tx_word << 1;
        o_mosi <= tx_word[TX_BITS-1];
        rx_sh  <= '0;
      end else if (abort) begin
        o_mosi <= 1'b0;
      end else if (state == TX && fall) begin
        tx_sh  <= tx_sh << 1;
        o_mosi <= (nxt == TX) ? tx_sh[TX_BITS-1] : 1'b0;
      end

      if (state == RX && rise) rx_sh <= {rx_sh[RX_BITS-2:0], i_miso};

      if (nxt == DONE) begin
        o_result <= rx_sh[RX_BITS-1:N];
        o_flags  <= rx_sh[N-1:0];
      end
    end
  end
endmodule

// File: tb/tb_spi_exe_master.sv
// Directed bench: two initiators (H=2/TURN=2 and H=1/TURN=0) against behavioural slaves.
module tb_spi_exe_master;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start0 = 0, abort0 = 0, start1 = 0, abort1 = 0;
  logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [3:0] op0 = 0, op1 = 0;
  logic [11:0] resp0 = 0, resp1 = 0;
  logic       busy0, done0, sck0, cs0, mosi0, miso0;
  logic       busy1, done1, sck1, cs1, mosi1, miso1;
  logic [7:0] res0, res1;
  logic [3:0] flg0, flg1;

  spi_exe_master #(.CLK_DIV(2), .TURN_BITS(2)) dut0 (
    .i_sclk(clk), .i_rst(rst), .i_start(start0), .i_abort(abort0),
    .i_argA(a0), .i_argB(b0), .i_oper(op0),
    .o_busy(busy0), .o_done(done0), .o_result(res0), .o_flags(flg0),
    .o_sck(sck0), .o_cs_n(cs0), .o_mosi(mosi0), .i_miso(miso0));

  spi_exe_master #(.CLK_DIV(1), .TURN_BITS(0)) dut1 (
    .i_sclk(clk), .i_rst(rst), .i_start(start1), .i_abort(abort1),
    .i_argA(a1), .i_argB(b1), .i_oper(op1),
    .o_busy(busy1), .o_done(done1), .o_result(res1), .o_flags(flg1),
    .o_sck(sck1), .o_cs_n(cs1), .o_mosi(mosi1), .i_miso(miso1));

  // Slave model: counts SCK rises in a CS window, captures MOSI, presents {result,flags} MSB first.
  for (genvar g = 0; g < 2; g++) begin : g_sl
    localparam int T = (g == 0) ? 2 : 0;
    logic sck_w, cs_w, mosi_w, miso_w;
    logic [11:0] rsp;
    int rcnt = 0;
    logic [23:0] mw = '0;
    assign sck_w  = (g == 0) ? sck0 : sck1;
    assign cs_w   = (g == 0) ? cs0 : cs1;
    assign mosi_w = (g == 0) ? mosi0 : mosi1;
    assign rsp    = (g == 0) ? resp0 : resp1;
    assign miso_w = (rcnt >= 24 + T && rcnt < 36 + T) ? rsp[35 + T - rcnt] : 1'b0;
    always @(posedge sck_w or posedge cs_w)
      if (cs_w) rcnt <= 0;
      else begin
        if (rcnt < 24) mw <= {mw[22:0], mosi_w};
        rcnt <= rcnt + 1;
      end
    if (g == 0) begin : g_m0
      assign miso0 = miso_w;
    end else begin : g_m1
      assign miso1 = miso_w;
    end
  end

  int done_cnt = 0, cs_win = 0;
  always @(posedge clk) if (done0) done_cnt <= done_cnt + 1;
  always @(negedge cs0) cs_win <= cs_win + 1;

  int checks = 0, errors = 0;
  int t0 = 0, t1 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic kick0(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       input logic [11:0] r);
    @(negedge clk); a0 = a; b0 = b; op0 = op; resp0 = r; start0 = 1;
    @(posedge clk); t0 = cyc;
    @(negedge clk); start0 = 0;
  endtask

  // Polls from cycle 1; optionally re-pulses start at cycle rej_at to probe busy rejection.
  task automatic wait0(input int rej_at, output int lat, output int busy_n);
    lat = -1; busy_n = 0;
    for (int i = 0; i < 400; i++) begin
      start0 = (cyc - t0 == rej_at);
      if (busy0) busy_n++;
      if (done0) begin lat = cyc - t0; break; end
      @(negedge clk);
    end
    start0 = 0;
  endtask

  initial begin
    int lat, bn, dc, cw;
    #12;
    chk("rst_cs",     32'(cs0),   32'h1);
    chk("rst_sck",    32'(sck0),  32'h0);
    chk("rst_busy",   32'(busy0), 32'h0);
    chk("rst_done",   32'(done0), 32'h0);
    chk("rst_result", 32'(res0),  32'h0);
    chk("rst_mosi",   32'(mosi0), 32'h0);
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);

    // Basic frame
    kick0(8'h05, 8'h03, 4'h0, {8'h08, 4'h0});
    wait0(-1, lat, bn);
    chk("basic_latency", 32'(lat), 32'd157);
    chk("basic_busy_after", 32'(busy0), 32'h0);
    chk("basic_result", 32'(res0), 32'h08);
    chk("basic_flags",  32'(flg0), 32'h0);
    chk("basic_mosi",   32'(g_sl[0].mw), 32'h050300);
    chk("basic_busy_cycles", 32'(bn), 32'd156);
    repeat (3) @(negedge clk);
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);

    // Abort at cycle 60 (mid-TX, just before an SCK rise)
    dc = done_cnt;
    kick0(8'h77, 8'h11, 4'h2, {8'h55, 4'hF});
    repeat (59) @(negedge clk);
    chk("abort_pre_cs", 32'(cs0), 32'h0);
    abort0 = 1;
    @(negedge clk); abort0 = 0;
    chk("abort_cs",   32'(cs0),   32'h1);
    chk("abort_sck",  32'(sck0),  32'h0);
    chk("abort_mosi", 32'(mosi0), 32'h0);
    chk("abort_busy", 32'(busy0), 32'h0);
    repeat (200) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(dc));
    chk("abort_result",  32'(res0), 32'h08);
    chk("abort_flags",   32'(flg0), 32'h0);

    // Flag capture with a rejected start at cycle 40
    dc = done_cnt; cw = cs_win;
    kick0(8'hFF, 8'h01, 4'h3, {8'h00, 4'hA});
    wait0(40, lat, bn);
    chk("flag_latency", 32'(lat), 32'd157);
    chk("flag_result",  32'(res0), 32'h00);
    chk("flag_flags",   32'(flg0), 32'hA);
    chk("flag_mosi_b3", 32'(g_sl[0].mw[7:0]), 32'h30);
    chk("flag_mosi",    32'(g_sl[0].mw), 32'hFF0130);
    chk("rej_busy_cycles", 32'(bn), 32'd156);
    repeat (200) @(negedge clk);
    chk("rej_done_cnt", 32'(done_cnt - dc), 32'd1);
    chk("rej_cs_windows", 32'(cs_win - cw), 32'd1);

    // Async reset mid-RX
    kick0(8'h12, 8'h34, 4'h5, {8'hC3, 4'h5});
    repeat (129) @(negedge clk);
    chk("rstrx_pre_cs", 32'(cs0), 32'h0);
    rst = 0;
    #1;
    chk("rstrx_cs",     32'(cs0),   32'h1);
    chk("rstrx_sck",    32'(sck0),  32'h0);
    chk("rstrx_busy",   32'(busy0), 32'h0);
    chk("rstrx_done",   32'(done0), 32'h0);
    chk("rstrx_result", 32'(res0),  32'h0);
    chk("rstrx_flags",  32'(flg0),  32'h0);
    chk("rstrx_mosi",   32'(mosi0), 32'h0);
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);
    kick0(8'h12, 8'h34, 4'h5, {8'hC3, 4'h5});
    wait0(-1, lat, bn);
    chk("fresh_latency", 32'(lat), 32'd157);
    chk("fresh_result",  32'(res0), 32'hC3);
    chk("fresh_flags",   32'(flg0), 32'h5);
    chk("fresh_mosi",    32'(g_sl[0].mw), 32'h123450);

    // H=1, no turnaround
    @(negedge clk); a1 = 8'hA5; b1 = 8'h5A; op1 = 4'hF; resp1 = {8'h96, 4'h6}; start1 = 1;
    @(posedge clk); t1 = cyc;
    @(negedge clk); start1 = 0;
    chk("h1_sck_low", 32'(sck1), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("h1_sck_high", 32'(sck1), 32'h1);
    @(negedge clk);
    chk("h1_sck_low2", 32'(sck1), 32'h0);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (done1) begin lat = cyc - t1; break; end
      @(negedge clk);
    end
    chk("h1_latency", 32'(lat), 32'd75);
    chk("h1_result",  32'(res1), 32'h96);
    chk("h1_flags",   32'(flg1), 32'h6);
    chk("h1_mosi",    32'(g_sl[1].mw), 32'hA55AF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_exe_master.md
Name: spi_exe_master

Overview:
- SPI initiator that drives the SPI execution-unit slave from the other end of the link.
- Takes a host request (argA, argB, 4-bit opcode) and runs one complete SPI frame: asserts chip select, shifts out three command bytes on MOSI, waits a turnaround, then captures result and flags from MISO.
- Returns the captured result and flags to the host with a done pulse.
- Sits between the on-chip host logic and the SPI pins; runs on i_sclk (system clock) and generates the serial clock by division.

Parameters:
- M, 8, argument/result width in bits.
- N, 4, opcode width; also the flag count.
- CLK_DIV, 2, i_sclk cycles per half-period of o_sck (H); legal range >=1.
- TURN_BITS, 2, dummy SPI clock periods between the opcode byte and the result field.

Ports:
- i_sclk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_start  in  1  request strobe; sampled only in IDLE.
- i_abort  in  1  terminates an active frame.
- i_argA  in  M  operand A; latched on accepted start.
- i_argB  in  M  operand B; latched on accepted start.
- i_oper  in  N  opcode; latched on accepted start.
- o_busy  out  1  high from the cycle after start acceptance until return to IDLE.
- o_done  out  1  one-cycle pulse when result/flags are valid.
- o_result  out  M  captured result; holds until the next o_done.
- o_flags  out  N  captured flags {BF,NF,OF,SF} (bit3..bit0); holds until the next o_done.
- o_sck  out  1  SPI clock; idle low (mode 0).
- o_cs_n  out  1  chip select, active low.
- o_mosi  out  1  serial data out, MSB first.
- i_miso  in  1  serial data in; sampled on o_sck rising edge.

Behaviour:
- Reset (async, any state): state=IDLE, o_sck=0, o_cs_n=1, o_mosi=0, o_busy=0, o_done=0, o_result=0, o_flags=0, all shift registers and counters=0. Reset mid-frame releases CS immediately with no done pulse.
- Registered outputs: every output is registered, so the pins are glitch-free.
- TX word: 24 bits = {argA, argB, {oper, 4'b0000}}. The opcode occupies the upper nibble of the third byte.
- RX word: M+N = 12 bits = {result, flags}, MSB first. Trailing slave padding bits are not clocked.
- Bit timing: each SPI bit is 2H i_sclk cycles. o_sck is low for the first H cycles and high for the next H. o_mosi updates at the start of the low phase. i_miso is registered on the cycle o_sck goes 0->1.
- State IDLE: o_cs_n=1, o_sck=0.
  - If i_start=1: latch inputs, go to SETUP.
- State SETUP: o_cs_n=0, o_sck=0, o_mosi=TX MSB, lasts H cycles, then go to TX.
- State TX: 24 bit periods, then go to TURN.
- State TURN: TURN_BITS bit periods, o_mosi=0, MISO ignored, then go to RX.
- State RX: 12 bit periods, shifting i_miso into the RX register, then go to HOLD.
- State HOLD: o_sck=0, o_cs_n=0, lasts H cycles, then go to DONE.
- State DONE (1 cycle):
  - o_cs_n=1, o_done=1, o_result/o_flags loaded from the RX register, o_busy=0.
  - Next state: IDLE.
  - A new i_start is not accepted in DONE; CS stays high for at least 2 cycles between frames.
- Latency: i_start sampled at edge 0 -> o_cs_n low from cycle 1 -> o_done high at cycle 1 + 2H + 2H*(36+TURN_BITS). For defaults this is cycle 157.
- i_start while busy: ignored; no queuing.
- i_abort in SETUP/TX/TURN/RX/HOLD:
  - Next cycle: o_cs_n=1, o_sck=0, o_mosi=0, state=IDLE.
  - No o_done; o_result/o_flags keep their previous values.
- i_abort in IDLE/DONE: no effect.
- i_abort and i_start together in IDLE: the start is accepted (abort has no effect in IDLE).
- Counters: the half-period counter wraps 0..H-1; the bit counter is sized for max(24,12,TURN_BITS); no arithmetic overflow is possible.

Decomposition:
- Package spi_exe_pkg, holding:
  - M, N, FLAG_W constants.
  - TX_BITS=24, RX_BITS=M+N.
  - Flag index constants SF=0, OF=1, NF=2, BF=3.
  - State enum typedef (IDLE, SETUP, TX, TURN, RX, HOLD, DONE).
- The slave side also imports this package.
- Sub-module spi_clk_gen: divide-by-CLK_DIV counter producing o_sck plus one-cycle rise/fall strobes, enabled by the FSM.

Test Plan:
- Basic frame: argA=0x05, argB=0x03, oper=0x0, H=2; slave model returns result=0x08, flags=0x0 -> MOSI bytes 0x05,0x03,0x00 captured by the model; o_done at cycle 157; o_result=0x08, o_flags=0x0.
- Flag capture: argA=0xFF, argB=0x01, oper=0x3; model returns result=0x00, flags=0xA -> o_result=0x00, o_flags=0xA; third MOSI byte=0x30.
- Busy rejection: second i_start pulse at cycle 40 -> exactly one CS-low window and one o_done; o_busy high cycles 1..156.
- Abort: i_abort at cycle 60 -> o_cs_n=1 and o_sck=0 at cycle 61; no o_done; o_result holds the prior 0x08.
- Async reset mid-RX: i_rst low at cycle 130 -> o_cs_n=1 and o_sck=0 immediately; all outputs 0; a fresh frame afterwards completes normally.
- CLK_DIV=1, TURN_BITS=0: o_sck period is 2 cycles; o_done at cycle 1 + 2 + 72 = 75; data is correct.
